// File: rtl/weight_load_sequencer.sv
// Weight-tile load sequencer: streams one weight row per cycle out of the
// weight buffer into the array preload registers, then broadcasts a single
// load_weight pulse once the array reports idle.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for start; an illegal num_rows gives a one-cycle err
// READ      | one buffer read per cycle, rows 0..num_rows-1
// WAIT_LOAD | last preload strobe in flight, then wait for array_idle
// DONE      | one-cycle done pulse; a new start may be accepted here
module weight_load_sequencer #(
  parameter int MATRIX_WIDTH = 4,
  parameter int BYTE_WIDTH   = 9,
  parameter int ADDR_WIDTH   = 8,
  localparam int CNT_W       = $clog2(MATRIX_WIDTH) + 1,
  localparam int DATA_W      = MATRIX_WIDTH * BYTE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [CNT_W-1:0]        num_rows,
  input  logic                    array_idle,
  output logic                    buf_rd_en,
  output logic [ADDR_WIDTH-1:0]   buf_rd_addr,
  input  logic [DATA_W-1:0]       buf_rd_data,
  output logic [DATA_W-1:0]       weight_out,
  output logic [MATRIX_WIDTH-1:0] preload_row,
  output logic                    load_weight,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ      = 2'd1,
    WAIT_LOAD = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        row_cnt_q;
  logic [CNT_W-1:0]        rows_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic                    rd_en_q;
  logic [MATRIX_WIDTH-1:0] preload_q;
  logic                    first_wait_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;

  logic                    rows_ok_d;
  logic                    last_row_d;
  logic                    load_fire_d;

  // Command legality and per-cycle decode used by the FSM and the load pulse.
  always_comb begin
    rows_ok_d   = (num_rows != '0) && (num_rows <= CNT_W'(MATRIX_WIDTH));
    last_row_d  = (row_cnt_q == rows_q - CNT_W'(1));
    // The first WAIT_LOAD cycle carries the last preload strobe, so the load
    // pulse is held off for one cycle to keep the two from overlapping.
    // array_idle is used directly so the pulse lands in the first idle cycle.
    load_fire_d = (state_q == WAIT_LOAD) && !first_wait_q && array_idle;
  end

  // Sequencing FSM with registered read, preload and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_cnt_q    <= '0;
      rows_q       <= '0;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      preload_q    <= '0;
      first_wait_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      preload_q <= '0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (start) begin
            if (rows_ok_d) begin
              state_q   <= READ;
              rows_q    <= num_rows;
              row_cnt_q <= '0;
              rd_addr_q <= base_addr;
              rd_en_q   <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        READ: begin
          // The preload strobe trails the read by one cycle, matching the
          // buffer's read latency so the row lands with its data.
          preload_q <= MATRIX_WIDTH'(1) << row_cnt_q;
          if (last_row_d) begin
            state_q      <= WAIT_LOAD;
            rd_en_q      <= 1'b0;
            first_wait_q <= 1'b1;
          end else begin
            row_cnt_q <= row_cnt_q + CNT_W'(1);
            rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
          end
        end
        WAIT_LOAD: begin
          first_wait_q <= 1'b0;
          if (load_fire_d) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign buf_rd_en   = rd_en_q;
  assign buf_rd_addr = rd_addr_q;
  assign weight_out  = buf_rd_data;
  assign preload_row = preload_q;
  assign load_weight = load_fire_d;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Directed bench for weight_load_sequencer with a one-cycle-latency buffer.
module tb_weight_load_sequencer;

  localparam int MW = 4;
  localparam int BW = 9;
  localparam int AW = 8;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [AW-1:0]  base_addr;
  logic [CW-1:0]  num_rows;
  logic           array_idle;
  logic           buf_rd_en;
  logic [AW-1:0]  buf_rd_addr;
  logic [MW*BW-1:0] buf_rd_data;
  logic [MW*BW-1:0] weight_out;
  logic [MW-1:0]  preload_row;
  logic           load_weight;
  logic           busy;
  logic           done;
  logic           err;

  int checks = 0;
  int errors = 0;

  weight_load_sequencer #(.MATRIX_WIDTH(MW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .array_idle(array_idle), .buf_rd_en(buf_rd_en),
    .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .weight_out(weight_out), .preload_row(preload_row),
    .load_weight(load_weight), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [MW*BW-1:0] pat(input logic [AW-1:0] a);
    return {1'b0, a, 1'b1, ~a, 1'b0, a ^ 8'h3C, 1'b1, a + 8'd7};
  endfunction

  // Weight buffer: data valid one cycle after the read enable.
  always @(posedge clk) begin
    if (buf_rd_en) buf_rd_data <= pat(buf_rd_addr);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cycle(input int c, input logic [AW-1:0] base, input int nrows, input int lc);
    logic [MW-1:0] pre;
    chk($sformatf("rd_en c%0d", c), 64'(buf_rd_en), 64'(c >= 1 && c <= nrows));
    if (c >= 1 && c <= nrows)
      chk($sformatf("rd_addr c%0d", c), 64'(buf_rd_addr), 64'(AW'(base + AW'(c - 1))));
    pre = (c >= 2 && c <= nrows + 1) ? MW'(1 << (c - 2)) : '0;
    chk($sformatf("preload c%0d", c), 64'(preload_row), 64'(pre));
    if (pre != '0)
      chk($sformatf("weight c%0d", c), 64'(weight_out), 64'(pat(AW'(base + AW'(c - 2)))));
    chk($sformatf("load_weight c%0d", c), 64'(load_weight), 64'(c == lc));
    chk($sformatf("busy c%0d", c), 64'(busy), 64'(c >= 1 && c <= lc));
    chk($sformatf("done c%0d", c), 64'(done), 64'(c == lc + 1));
    chk($sformatf("err c%0d", c), 64'(err), 64'(0));
  endtask

  task automatic expect_quiet(input string tag);
    chk({tag, " rd_en"}, 64'(buf_rd_en), 64'(0));
    chk({tag, " preload"}, 64'(preload_row), 64'(0));
    chk({tag, " load_weight"}, 64'(load_weight), 64'(0));
    chk({tag, " busy"}, 64'(busy), 64'(0));
    chk({tag, " done"}, 64'(done), 64'(0));
  endtask

  // Start at cycle 0, then check every cycle up to and including DONE.
  task automatic run_cmd(input logic [AW-1:0] base, input int nrows, input int idle_from, input int dup_start);
    int lc;
    cyc();
    base_addr  = base;
    num_rows   = CW'(nrows);
    start      = 1'b1;
    array_idle = (idle_from <= 0);
    lc = (idle_from > nrows + 2) ? idle_from : nrows + 2;
    for (int c = 1; c <= lc + 1; c++) begin
      cyc();
      start = (c == dup_start);
      if (c == dup_start) begin
        base_addr = 8'hAA;
        num_rows  = 3'd2;
      end
      array_idle = (c >= idle_from);
      #1;
      expect_cycle(c, base, nrows, lc);
    end
    start = 1'b0;
  endtask

  task automatic run_err(input int nrows);
    cyc();
    base_addr = 8'h40;
    num_rows  = CW'(nrows);
    start     = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    chk($sformatf("err pulse n%0d", nrows), 64'(err), 64'(1));
    expect_quiet($sformatf("err c1 n%0d", nrows));
    cyc();
    #1;
    chk($sformatf("err clear n%0d", nrows), 64'(err), 64'(0));
    expect_quiet($sformatf("err c2 n%0d", nrows));
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    num_rows   = '0;
    array_idle = 1'b1;
    cyc();
    cyc();
    #1;
    expect_quiet("reset");
    chk("reset err", 64'(err), 64'(0));
    chk("reset rd_addr", 64'(buf_rd_addr), 64'(0));
    rst = 1'b0;

    // Full tile, array idle throughout.
    run_cmd(8'h10, 4, 0, -1);
    // Array busy until cycle 10.
    run_cmd(8'h10, 4, 10, -1);
    // Address wrap, partial tile.
    run_cmd(8'hFE, 3, 0, -1);
    // Illegal row counts.
    run_err(0);
    run_err(5);
    // Single row with a start while busy.
    run_cmd(8'h33, 1, 0, 2);

    // Reset in the middle of a full tile.
    cyc();
    base_addr  = 8'h10;
    num_rows   = 3'd4;
    start      = 1'b1;
    array_idle = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      start = 1'b0;
      rst   = (c == 3);
      #1;
      expect_cycle(c, 8'h10, 4, 6);
    end
    for (int c = 4; c <= 5; c++) begin
      cyc();
      rst = 1'b0;
      #1;
      expect_quiet($sformatf("post-reset c%0d", c));
      chk($sformatf("post-reset err c%0d", c), 64'(err), 64'(0));
    end
    run_cmd(8'h10, 4, 0, -1);

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
